// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vend event codes and indicator state encoding
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ON    = 2'b01,
    ST_OFF   = 2'b10,
    ST_CHASE = 2'b11
  } state_t;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SOLD   = 2'b01;
  localparam logic [1:0] EV_CHANGE = 2'b10;
  localparam logic [1:0] EV_FAULT  = 2'b11;

  // Two full rotations of the four-lamp running light
  localparam int CHASE_STEPS = 8;

  function automatic logic [3:0] mask_for(input logic [1:0] code);
    return (code == EV_CHANGE) ? 4'b0011 : 4'b0001;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - free-running phase counter that flags the last cycle of each phase
module phase_timer #(
  parameter int TICK_MAX = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic done
);

  localparam int W = $clog2(TICK_MAX);
  localparam logic [W-1:0] LAST = W'(TICK_MAX - 1);

  logic [W-1:0] cnt;

  // Wrapping on done makes back-to-back phases start at zero without help from the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = !clear && (cnt == LAST);

endmodule

// File: rtl/vend_indicator.sv
// rtl/vend_indicator.sv - LED blink/chase sequencer for vend events with one pending slot
module vend_indicator
  import vend_pkg::*;
#(
  parameter int TICK_MAX = 12_500_000,
  parameter int BLINKS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] flag_sd,
  output logic [3:0] led,
  output logic       busy,
  output logic       drop
);

  localparam int PW = $clog2(BLINKS + 1);
  localparam int SW = $clog2(CHASE_STEPS);
  localparam logic [PW-1:0] PAIR_LAST = PW'(BLINKS);
  localparam logic [SW-1:0] STEP_LAST = SW'(CHASE_STEPS - 1);

  state_t        state;
  logic [3:0]    mask;
  logic [PW-1:0] pair;
  logic [SW-1:0] step;
  logic          pend_valid;
  logic [1:0]    pend_code;

  logic          done;
  logic          event_in;
  logic          seq_end;
  logic          start_now;
  logic [1:0]    start_code;

  phase_timer #(.TICK_MAX(TICK_MAX)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_IDLE),
    .done  (done)
  );

  assign event_in = (flag_sd != EV_NONE);
  assign seq_end  = done && (((state == ST_OFF) && (pair == PAIR_LAST)) ||
                             ((state == ST_CHASE) && (step == STEP_LAST)));

  // A held event always wins over one arriving on the same ending edge
  assign start_now  = ((state == ST_IDLE) && event_in) ||
                      (seq_end && (pend_valid || event_in));
  assign start_code = (seq_end && pend_valid) ? pend_code : flag_sd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mask       <= 4'b0000;
      pair       <= '0;
      step       <= '0;
      pend_valid <= 1'b0;
      pend_code  <= EV_NONE;
      led        <= 4'b0000;
      busy       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      drop <= 1'b0;

      case (state)
        ST_ON:    led <= mask;
        ST_CHASE: led <= 4'b0001 << step[1:0];
        default:  led <= 4'b0000;
      endcase

      if (start_now) begin
        state <= (start_code == EV_FAULT) ? ST_CHASE : ST_ON;
        mask  <= mask_for(start_code);
        pair  <= '0;
        step  <= '0;
        busy  <= 1'b1;
      end else if (seq_end) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (done) begin
        case (state)
          ST_ON: begin
            state <= ST_OFF;
            pair  <= pair + 1'b1;
          end
          ST_OFF:   state <= ST_ON;
          ST_CHASE: step  <= step + 1'b1;
          default:  state <= ST_IDLE;
        endcase
      end

      // Pending slot: freed when its event starts, refilled by a same-edge arrival
      if (seq_end) begin
        if (pend_valid) begin
          pend_valid <= event_in;
          pend_code  <= flag_sd;
        end
      end else if ((state != ST_IDLE) && event_in) begin
        if (pend_valid) begin
          drop <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_code  <= flag_sd;
        end
      end
    end
  end

endmodule

// File: tb/tb_vend_indicator.sv
// tb/tb_vend_indicator.sv - randomized and directed check of vend_indicator against a pattern model
module tb_vend_indicator;

  localparam int TICK = 4;
  localparam int BL   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] flag_sd = 2'b00;
  logic [3:0] led;
  logic       busy;
  logic       drop;

  int n_assert = 0;
  int n_fail   = 0;

  vend_indicator #(.TICK_MAX(TICK), .BLINKS(BL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flag_sd (flag_sd),
    .led     (led),
    .busy    (busy),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: each accepted event expands into the list of led values it shows, one per cycle
  bit         m_active;
  bit         m_pv;
  logic [1:0] m_pc;
  logic [3:0] m_pat[$];
  int         m_pos;
  logic [3:0] e_led;
  logic       e_busy;
  logic       e_drop;

  task automatic m_start(input logic [1:0] c);
    m_pat.delete();
    if (c == 2'b11) begin
      for (int s = 0; s < 8; s++)
        for (int k = 0; k < TICK; k++) m_pat.push_back(4'(1 << (s % 4)));
    end else begin
      for (int b = 0; b < BL; b++) begin
        for (int k = 0; k < TICK; k++) m_pat.push_back((c == 2'b10) ? 4'b0011 : 4'b0001);
        for (int k = 0; k < TICK; k++) m_pat.push_back(4'b0000);
      end
    end
    m_pos    = 0;
    m_active = 1'b1;
  endtask

  always @(posedge clk) begin : model
    logic [1:0] f;
    f = flag_sd;
    if (!rst_n) begin
      m_active = 1'b0;
      m_pv     = 1'b0;
      m_pc     = 2'b00;
      m_pat.delete();
      m_pos    = 0;
      e_led    = 4'b0000;
      e_busy   = 1'b0;
      e_drop   = 1'b0;
    end else begin
      e_drop = 1'b0;
      e_led  = m_active ? m_pat[m_pos] : 4'b0000;
      if (m_active) begin
        m_pos++;
        if (m_pos == m_pat.size()) begin
          if (m_pv) begin
            m_start(m_pc);
            m_pv = (f != 2'b00);
            m_pc = f;
          end else if (f != 2'b00) begin
            m_start(f);
          end else begin
            m_active = 1'b0;
          end
        end else if (f != 2'b00) begin
          if (m_pv) e_drop = 1'b1;
          else begin
            m_pv = 1'b1;
            m_pc = f;
          end
        end
      end else if (f != 2'b00) begin
        m_start(f);
      end
      e_busy = m_active;
    end
    #1;
    check("model_led", 32'(led), 32'(e_led));
    check("model_busy", 32'(busy), 32'(e_busy));
    check("model_drop", 32'(drop), 32'(e_drop));
  end

  logic [3:0] s_led;
  logic       s_busy;
  logic       s_drop;

  task automatic cyc(input logic [1:0] f);
    @(negedge clk);
    s_led   = led;
    s_busy  = busy;
    s_drop  = drop;
    flag_sd = f;
  endtask

  logic [1:0] stim[100];
  int c_busy, c_busy_fall, c_drop, c_l0, c_l0_rise, c_m3, c_m4, c_other;

  task automatic run(input int n);
    logic [3:0] prev;
    logic       pb;
    prev = 4'b0000;
    pb   = 1'b0;
    c_busy = 0; c_busy_fall = 0; c_drop = 0; c_l0 = 0;
    c_l0_rise = 0; c_m3 = 0; c_m4 = 0; c_other = 0;
    for (int i = 0; i < n; i++) begin
      cyc(stim[i]);
      c_busy += int'(s_busy);
      c_drop += int'(s_drop);
      c_l0   += int'(s_led[0]);
      if (s_led[0] && !prev[0]) c_l0_rise++;
      if (pb && !s_busy) c_busy_fall++;
      if (s_led == 4'b0011) c_m3++;
      if (s_led == 4'b0100) c_m4++;
      if (s_led != 4'b0000 && s_led != 4'b0001 && s_led != 4'b0011) c_other++;
      prev = s_led;
      pb   = s_busy;
    end
    for (int i = 0; i < 100; i++) stim[i] = 2'b00;
  endtask

  initial begin
    logic [3:0] seen[$];
    logic [3:0] prev;
    int         nz;
    logic [1:0] rf;

    for (int i = 0; i < 100; i++) stim[i] = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop", 32'(drop), 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc(2'b00);

    stim[0] = 2'b01;
    run(42);
    check("sold_busy_cycles", 32'(c_busy), 32'd24);
    check("sold_led0_cycles", 32'(c_l0), 32'd12);
    check("sold_pairs", 32'(c_l0_rise), 32'd3);
    check("sold_end_led", 32'(s_led), 32'd0);
    check("sold_end_busy", 32'(s_busy), 32'd0);

    stim[0] = 2'b10;
    run(42);
    check("change_on_cycles", 32'(c_m3), 32'd12);
    check("change_stray_led", 32'(c_other), 32'd0);
    check("change_end_led", 32'(s_led), 32'd0);

    cyc(2'b11);
    prev = 4'b0000;
    nz   = 0;
    for (int i = 0; i < 45; i++) begin
      cyc(2'b00);
      if (s_led != 4'b0000) nz++;
      if (s_led != prev && s_led != 4'b0000) seen.push_back(s_led);
      prev = s_led;
    end
    check("chase_lit_cycles", 32'(nz), 32'd32);
    check("chase_steps", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check("chase_step_value", 32'(seen[i]), 32'(1 << (i % 4)));
    check("chase_end_led", 32'(s_led), 32'd0);

    stim[0] = 2'b01;
    stim[5] = 2'b10;
    stim[9] = 2'b11;
    run(70);
    check("queue_drop_count", 32'(c_drop), 32'd1);
    check("queue_no_chase", 32'(c_m4), 32'd0);
    check("queue_change_on", 32'(c_m3), 32'd12);
    check("queue_busy_cycles", 32'(c_busy), 32'd48);
    check("queue_busy_gapless", 32'(c_busy_fall), 32'd1);

    stim[0] = 2'b01;
    stim[3] = 2'b10;
    run(10);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n   = 1'b0;
    flag_sd = 2'b11;
    #1;
    check("abort_led", 32'(led), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    flag_sd = 2'b00;
    rst_n   = 1'b1;
    run(25);
    check("abort_stays_idle", 32'(c_busy), 32'd0);
    check("abort_led_dark", 32'(c_l0 + c_m3 + c_m4 + c_other), 32'd0);

    stim[0]  = 2'b01;
    stim[24] = 2'b01;
    run(60);
    check("back2back_busy", 32'(c_busy), 32'd48);
    check("back2back_gapless", 32'(c_busy_fall), 32'd1);
    check("back2back_drop", 32'(c_drop), 32'd0);
    check("back2back_pairs", 32'(c_l0_rise), 32'd6);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 2) begin
        @(negedge clk);
        rst_n   = 1'b0;
        flag_sd = 2'($urandom_range(0, 3));
        repeat (2) @(negedge clk);
        flag_sd = 2'b00;
        rst_n   = 1'b1;
      end else begin
        rf = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        cyc(rf);
      end
    end
    repeat (80) cyc(2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
